// File: rtl/package_settings.sv
// Project-wide data-path widths shared by the filter chain.
package package_settings;

  localparam int SIZE_FILTER_DATA = 16;

endpackage

// File: rtl/pd_parameter.sv
// Shared types and default timing values for the pulse peak detectors.
package pd_parameter;

  localparam int unsigned HOLDOFF_DEFAULT   = 16;
  localparam int unsigned MAX_WIDTH_DEFAULT = 256;

  typedef enum logic [1:0] {
    StIdle,
    StRise,
    StHoldoff
  } peak_state_t;

endpackage

// File: rtl/filter_peak_detector_out_buffer.sv
// Single-entry valid/ready record register; records arriving while it is full and
// not being drained are dropped and counted in a saturating counter.
module peak_out_buffer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TS_WIDTH   = 32,
  parameter int unsigned LOST_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] amp_i,
  input  logic [TS_WIDTH-1:0]   time_i,
  input  logic                  pileup_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] amp_o,
  output logic [TS_WIDTH-1:0]   time_o,
  output logic                  pileup_o,
  output logic [LOST_WIDTH-1:0] lost_count_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] amp_q, amp_d;
  logic [TS_WIDTH-1:0]   time_q, time_d;
  logic                  pileup_q, pileup_d;
  logic [LOST_WIDTH-1:0] lost_q, lost_d;

  always_comb begin
    valid_d  = valid_q;
    amp_d    = amp_q;
    time_d   = time_q;
    pileup_d = pileup_q;
    lost_d   = lost_q;
    if (push_i) begin
      // A record being drained this cycle frees the slot for the new one.
      if (!valid_q || ready_i) begin
        valid_d  = 1'b1;
        amp_d    = amp_i;
        time_d   = time_i;
        pileup_d = pileup_i;
      end else if (lost_q != '1) begin
        lost_d = lost_q + 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      amp_q    <= '0;
      time_q   <= '0;
      pileup_q <= 1'b0;
      lost_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      amp_q    <= amp_d;
      time_q   <= time_d;
      pileup_q <= pileup_d;
      lost_q   <= lost_d;
    end
  end

  assign valid_o      = valid_q;
  assign amp_o        = amp_q;
  assign time_o       = time_q;
  assign pileup_o     = pileup_q;
  assign lost_count_o = lost_q;

endmodule

// File: rtl/filter_peak_detector.sv
// Threshold-crossing pulse detector: tracks each pulse maximum and its timestamp and
// emits one record per pulse through a single-entry output buffer.
module filter_peak_detector
  import package_settings::*;
  import pd_parameter::*;
#(
  parameter int unsigned TS_WIDTH   = 32,
  parameter int unsigned HOLDOFF    = HOLDOFF_DEFAULT,
  parameter int unsigned MAX_WIDTH  = MAX_WIDTH_DEFAULT,
  parameter int unsigned LOST_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SIZE_FILTER_DATA-1:0] filter_data,
  input  logic [SIZE_FILTER_DATA-1:0] threshold,
  output logic [SIZE_FILTER_DATA-1:0] peak_amplitude,
  output logic [TS_WIDTH-1:0]         peak_time,
  output logic                        peak_pileup,
  output logic                        peak_valid,
  input  logic                        peak_ready,
  output logic [LOST_WIDTH-1:0]       lost_count,
  output logic                        busy
);

  localparam int unsigned WcW = $clog2(MAX_WIDTH) + 1;
  localparam int unsigned HcW = $clog2(HOLDOFF + 1) + 1;
  localparam logic [WcW-1:0] WcLast = WcW'(MAX_WIDTH - 1);
  localparam logic [HcW-1:0] HcLast = HcW'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);
  localparam peak_state_t StAfterEmit = (HOLDOFF == 0) ? StIdle : StHoldoff;

  peak_state_t                   state_q, state_d;
  logic [TS_WIDTH-1:0]           ts_q;
  logic signed [SIZE_FILTER_DATA-1:0] thr_q, thr_d;
  logic signed [SIZE_FILTER_DATA-1:0] max_q, max_d;
  logic [TS_WIDTH-1:0]           tmax_q, tmax_d;
  logic [WcW-1:0]                wcnt_q, wcnt_d;
  logic [HcW-1:0]                hcnt_q, hcnt_d;
  logic                          armed_q, armed_d;
  logic signed [SIZE_FILTER_DATA-1:0] sample;

  logic                          emit;
  logic                          emit_pileup;
  logic [SIZE_FILTER_DATA-1:0]   emit_amp;
  logic [TS_WIDTH-1:0]           emit_time;

  assign sample = filter_data;

  always_comb begin
    state_d     = state_q;
    thr_d       = thr_q;
    max_d       = max_q;
    tmax_d      = tmax_q;
    wcnt_d      = wcnt_q;
    hcnt_d      = hcnt_q;
    armed_d     = armed_q;
    emit        = 1'b0;
    emit_pileup = 1'b0;
    emit_amp    = max_q;
    emit_time   = tmax_q;
    unique case (state_q)
      StIdle: begin
        thr_d = threshold;
        // After a timeout the input must drop to threshold before a new pulse can start.
        if (sample <= thr_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = StRise;
          max_d   = sample;
          tmax_d  = ts_q;
          wcnt_d  = WcW'(1);
        end
      end
      StRise: begin
        if (sample <= thr_q) begin
          emit    = 1'b1;
          state_d = StAfterEmit;
          hcnt_d  = '0;
        end else begin
          if (sample > max_q) begin
            max_d  = sample;
            tmax_d = ts_q;
          end
          if (wcnt_q == WcLast) begin
            emit        = 1'b1;
            emit_pileup = 1'b1;
            emit_amp    = (sample > max_q) ? sample : max_q;
            emit_time   = (sample > max_q) ? ts_q : tmax_q;
            armed_d     = 1'b0;
            state_d     = StAfterEmit;
            hcnt_d      = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      StHoldoff: begin
        if (hcnt_q == HcLast) begin
          state_d = StIdle;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ts_q    <= '0;
      thr_q   <= '0;
      max_q   <= '0;
      tmax_q  <= '0;
      wcnt_q  <= '0;
      hcnt_q  <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + 1'b1;
      thr_q   <= thr_d;
      max_q   <= max_d;
      tmax_q  <= tmax_d;
      wcnt_q  <= wcnt_d;
      hcnt_q  <= hcnt_d;
      armed_q <= armed_d;
    end
  end

  assign busy = (state_q != StIdle);

  peak_out_buffer #(
    .DATA_WIDTH(SIZE_FILTER_DATA),
    .TS_WIDTH  (TS_WIDTH),
    .LOST_WIDTH(LOST_WIDTH)
  ) u_out_buffer (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (emit),
    .amp_i       (emit_amp),
    .time_i      (emit_time),
    .pileup_i    (emit_pileup),
    .ready_i     (peak_ready),
    .valid_o     (peak_valid),
    .amp_o       (peak_amplitude),
    .time_o      (peak_time),
    .pileup_o    (peak_pileup),
    .lost_count_o(lost_count)
  );

endmodule

// File: tb/tb_filter_peak_detector.sv
// Directed bench for filter_peak_detector with HOLDOFF=4 and MAX_WIDTH=8.
module tb_filter_peak_detector;
  import package_settings::*;

  localparam int W = SIZE_FILTER_DATA;

  logic          clk;
  logic          reset;
  logic [W-1:0]  filter_data;
  logic [W-1:0]  threshold;
  logic [W-1:0]  peak_amplitude;
  logic [31:0]   peak_time;
  logic          peak_pileup;
  logic          peak_valid;
  logic          peak_ready;
  logic [15:0]   lost_count;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int ts_model = 0;
  int cur_ts = 0;
  int t_peak = 0;
  int seen = 0;

  filter_peak_detector #(
    .TS_WIDTH  (32),
    .HOLDOFF   (4),
    .MAX_WIDTH (8),
    .LOST_WIDTH(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .filter_data   (filter_data),
    .threshold     (threshold),
    .peak_amplitude(peak_amplitude),
    .peak_time     (peak_time),
    .peak_pileup   (peak_pileup),
    .peak_valid    (peak_valid),
    .peak_ready    (peak_ready),
    .lost_count    (lost_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  // Present one sample, let the edge consume it, then settle past the edge.
  task automatic tick(input int d);
    logic [31:0] v;
    v = d;
    filter_data = v[W-1:0];
    cur_ts = ts_model;
    if (reset) ts_model = 0;
    else ts_model = ts_model + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick(0);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    threshold   = 16'd100;
    peak_ready  = 1'b1;
    filter_data = '0;
    settle(3);
    check("rst_valid", 64'(peak_valid), 0);
    check("rst_amp", 64'(peak_amplitude), 0);
    check("rst_time", 64'(peak_time), 0);
    check("rst_pileup", 64'(peak_pileup), 0);
    check("rst_lost", 64'(lost_count), 0);
    check("rst_busy", 64'(busy), 0);

    // Single pulse: 150 arrives at ts=2, peak 420 at ts=4.
    reset = 1'b0;
    tick(0);
    tick(50);
    check("p1_idle", 64'(busy), 0);
    tick(150);
    check("p1_busy", 64'(busy), 1);
    tick(300);
    tick(420);
    tick(380);
    tick(200);
    check("p1_novalid", 64'(peak_valid), 0);
    tick(90);
    check("p1_valid", 64'(peak_valid), 1);
    check("p1_amp", 64'(peak_amplitude), 420);
    check("p1_time", 64'(peak_time), 4);
    check("p1_pileup", 64'(peak_pileup), 0);
    tick(0);
    check("p1_drain", 64'(peak_valid), 0);
    settle(2);
    check("p1_holdoff", 64'(busy), 1);
    tick(0);
    check("p1_idle_after", 64'(busy), 0);

    // Flat top keeps the first maximum.
    tick(0);
    tick(200);
    tick(500);
    t_peak = cur_ts;
    tick(500);
    tick(500);
    tick(50);
    check("flat_amp", 64'(peak_amplitude), 500);
    check("flat_time", 64'(peak_time), 64'(t_peak));
    settle(6);

    // Long pulse forces a timeout after eight samples above threshold.
    for (int i = 1; i <= 8; i++) begin
      tick(300);
      if (i == 1) t_peak = cur_ts;
      if (i == 7) check("long_early", 64'(peak_valid), 0);
    end
    check("long_valid", 64'(peak_valid), 1);
    check("long_amp", 64'(peak_amplitude), 300);
    check("long_pileup", 64'(peak_pileup), 1);
    check("long_time", 64'(peak_time), 64'(t_peak));
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(300);
      if (peak_valid) seen++;
    end
    check("long_no_second", 64'(seen), 0);
    check("long_idle", 64'(busy), 0);
    tick(0);
    tick(250);
    check("long_rearm", 64'(busy), 1);
    tick(0);
    check("rearm_amp", 64'(peak_amplitude), 250);
    check("rearm_pileup", 64'(peak_pileup), 0);
    settle(6);

    // Backpressure: first record held, the next two are lost.
    peak_ready = 1'b0;
    tick(200);
    tick(0);
    check("bp_valid1", 64'(peak_valid), 1);
    settle(6);
    tick(300);
    tick(0);
    check("bp_lost1", 64'(lost_count), 1);
    settle(6);
    tick(400);
    tick(0);
    check("bp_lost2", 64'(lost_count), 2);
    check("bp_amp", 64'(peak_amplitude), 200);
    check("bp_valid", 64'(peak_valid), 1);
    peak_ready = 1'b1;
    tick(0);
    check("bp_drain", 64'(peak_valid), 0);
    settle(5);

    // Emit coinciding with a drain replaces the record without loss.
    peak_ready = 1'b0;
    tick(200);
    tick(0);
    check("sim_old", 64'(peak_amplitude), 200);
    settle(6);
    tick(350);
    t_peak = cur_ts;
    peak_ready = 1'b1;
    tick(0);
    check("sim_valid", 64'(peak_valid), 1);
    check("sim_amp", 64'(peak_amplitude), 350);
    check("sim_time", 64'(peak_time), 64'(t_peak));
    check("sim_lost", 64'(lost_count), 2);
    tick(0);
    check("sim_drain", 64'(peak_valid), 0);
    settle(5);

    // Negative input below a negative threshold never triggers.
    threshold = -16'sd100;
    tick(0);
    tick(-500);
    tick(-500);
    check("neg_busy", 64'(busy), 0);
    check("neg_valid", 64'(peak_valid), 0);
    threshold = 16'd100;
    tick(-500);
    tick(0);
    check("neg_restore", 64'(busy), 0);

    // Raising the threshold mid-pulse does not affect the pulse in progress.
    tick(500);
    threshold = 16'd1000;
    tick(600);
    tick(50);
    check("thr_valid", 64'(peak_valid), 1);
    check("thr_amp", 64'(peak_amplitude), 600);
    threshold = 16'd100;
    settle(6);

    // Reset during a pulse discards everything.
    tick(300);
    check("rstp_busy", 64'(busy), 1);
    reset = 1'b1;
    tick(0);
    check("rstp_busy0", 64'(busy), 0);
    check("rstp_valid", 64'(peak_valid), 0);
    check("rstp_lost", 64'(lost_count), 0);
    check("rstp_amp", 64'(peak_amplitude), 0);
    reset = 1'b0;
    settle(3);
    check("rstp_norec", 64'(peak_valid), 0);
    check("rstp_idle", 64'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
